// File: rtl/norm_shifter.sv
// Iterative left-normalizer: shifts A left until its leading 1 reaches the MSB and reports the shift count.
// Optional NORM_SIGNED_EN adds an is_signed input that normalizes on the leading sign-differing bit instead.
module norm_shifter #(
  parameter  int unsigned W  = 32,
  localparam int unsigned SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  A,
`ifdef NORM_SIGNED_EN
  input  logic          is_signed,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  norm,
  output logic [SW-1:0] shamt,
  output logic          zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  work;
  logic [SW-1:0] count;
  logic          zero_q;
  logic          stop_c;
  logic          a_zero_c;
  logic          a_degen_c;

  assign a_zero_c = (A == '0);

`ifdef NORM_SIGNED_EN
  logic signed_q;

  // Signed mode stops once the top two bits differ; an all-ones operand stops on the count limit.
  assign stop_c    = signed_q ? ((work[W-1] != work[W-2]) || (count == SW'(W-1)))
                              : work[W-1];
  assign a_degen_c = a_zero_c || (is_signed && (A == '1));
`else
  assign stop_c    = work[W-1];
  assign a_degen_c = a_zero_c;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      work   <= '0;
      count  <= '0;
      zero_q <= 1'b0;
`ifdef NORM_SIGNED_EN
      signed_q <= 1'b0;
`endif
    end else if (flush) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work   <= A;
            count  <= '0;
            zero_q <= a_degen_c;
`ifdef NORM_SIGNED_EN
            signed_q <= is_signed;
`endif
            // An all-zero operand has nothing to shift and skips straight to DONE.
            state  <= a_zero_c ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          if (stop_c) begin
            state <= DONE;
          end else begin
            work  <= work << 1;
            count <= count + SW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign norm      = work;
  assign shamt     = count;
  assign zero      = zero_q;

endmodule

// File: tb/tb_norm_shifter.sv
// Randomized self-checking bench for norm_shifter against a leading-bit-count reference model.
// Build with NORM_SIGNED_EN defined to also exercise the signed normalization mode.
module tb_norm_shifter;

  localparam int unsigned W  = 32;
  localparam int unsigned SW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic          is_signed;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  norm;
  logic [SW-1:0] shamt;
  logic          zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  norm_shifter #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
`ifdef NORM_SIGNED_EN
    .is_signed (is_signed),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .norm      (norm),
    .shamt     (shamt),
    .zero      (zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: count redundant leading bits directly from the operand value.
  task automatic ref_model(input logic [W-1:0] v, input bit sgn,
                           output int sh, output logic [W-1:0] nv,
                           output bit z, output int lat);
    sh = 0;
    z  = 1'b0;
    if (v == '0) begin
      nv  = '0;
      z   = 1'b1;
      lat = 1;
    end else begin
      if (sgn) begin
        for (int i = W - 2; i >= 0; i--) begin
          if (v[i] != v[W-1]) break;
          sh++;
        end
        z = (v == '1);
      end else begin
        for (int i = W - 1; i >= 0; i--) begin
          if (v[i]) break;
          sh++;
        end
      end
      nv  = v << sh;
      lat = 2 + sh;
    end
  endtask

  // One full transaction; entered and left at posedge+1 with the block idle.
  task automatic do_op(input logic [W-1:0] v, input bit sgn, input int stall);
    int            sh;
    int            lat;
    int            k;
    bit            z;
    logic [W-1:0]  nv;
    ref_model(v, sgn, sh, nv, z, lat);
    check("idle_ready", 64'(in_ready), 64'(1));
    a         = v;
    is_signed = sgn;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    k = 1;
    while (!out_valid && k < 4 * W) begin
      @(posedge clk); #1;
      k++;
    end
    check("latency", 64'(k), 64'(lat));
    check("norm", 64'(norm), 64'(nv));
    check("shamt", 64'(shamt), 64'(sh));
    check("zero", 64'(zero), 64'(z));
    check("done_not_ready", 64'(in_ready), 64'(0));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 64'(out_valid), 64'(1));
      check("stall_norm", 64'(norm), 64'(nv));
      check("stall_shamt", 64'(shamt), 64'(sh));
      check("stall_zero", 64'(zero), 64'(z));
      check("stall_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("exit_valid", 64'(out_valid), 64'(0));
    check("exit_ready", 64'(in_ready), 64'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_norm"}, 64'(norm), 64'(0));
    check({tag, "_shamt"}, 64'(shamt), 64'(0));
    check({tag, "_zero"}, 64'(zero), 64'(0));
  endtask

  initial begin
    logic [W-1:0] v;
    bit           sgn;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    is_signed = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    do_op(32'h8000_0000, 1'b0, 0);
    do_op(32'h0000_0001, 1'b0, 0);
    do_op(32'h0001_2345, 1'b0, 5);
    do_op(32'h0000_0000, 1'b0, 0);
    do_op(32'hFFFF_FFFF, 1'b0, 1);

    // Flush mid-SHIFT discards the operation
    a = 32'h0000_00F0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("flush_c1_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    check("flush_c2_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    check("flush_c3_valid", 64'(out_valid), 64'(0));
    flush = 1'b1; in_valid = 1'b1; a = 32'h0000_0001;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle", 64'(in_ready), 64'(1));
    check("flush_shamt", 64'(shamt), 64'(0));
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      check("flush_no_valid", 64'(out_valid), 64'(0));
    end

    // in_valid is ignored while flush is asserted in IDLE
    flush = 1'b1; in_valid = 1'b1; a = 32'h0000_0010;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_ignores_in", 64'(in_ready), 64'(1));
    do_op(32'h4000_0000, 1'b0, 0);

    // Async reset mid-SHIFT
    a = 32'h0000_00F0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_busy", 64'(in_ready), 64'(0));
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", 64'(in_ready), 64'(1));
    check("post_rst_valid", 64'(out_valid), 64'(0));
    do_op(32'h0000_0300, 1'b0, 0);

`ifdef NORM_SIGNED_EN
    do_op(32'hFFFF_FF00, 1'b1, 0);
    do_op(32'hFFFF_FFFF, 1'b1, 2);
    do_op(32'h0000_0003, 1'b1, 0);
    do_op(32'h0000_0000, 1'b1, 0);
    do_op(32'h8000_0000, 1'b1, 0);
`endif

    // Randomized operands with varied magnitude and output stalls
    for (int n = 0; n < 60; n++) begin
      v = W'($urandom) >> $urandom_range(0, W - 1);
      if ($urandom_range(0, 9) == 0) v = '0;
`ifdef NORM_SIGNED_EN
      sgn = 1'($urandom_range(0, 1));
      if (sgn && $urandom_range(0, 1) == 1) v = ~v;
`else
      sgn = 1'b0;
`endif
      do_op(v, sgn, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
